// File: rtl/simple_processor_pkg.sv
// Shared definitions for the simple processor execute stage: datapath width
// and the logic-unit function encoding.
package simple_processor_pkg;

  localparam int DATA_WIDTH = 32;

  // Codes 3'd5..3'd7 are unnamed and decode as unsupported, the same as FUNC_INVALID.
  typedef enum logic [2:0] {
    FUNC_AND     = 3'd0,
    FUNC_OR      = 3'd1,
    FUNC_XOR     = 3'd2,
    FUNC_NOT     = 3'd3,
    FUNC_INVALID = 3'd4
  } func_t;

endpackage

// File: rtl/alu_gate_comb.sv
// Combinational core of the bitwise logic unit: produces the next result and
// flags function codes the unit does not implement.
module alu_gate_comb
  import simple_processor_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  func_t                 func_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  invalid_o
);

  always_comb begin
    // NOTE: defaults are assigned before the case so every path drives both outputs and no latch is inferred.
    result_o  = '0;
    invalid_o = 1'b0;
    case (func_i)
      FUNC_AND: result_o = rs1_data_i & rs2_data_i;
      FUNC_OR:  result_o = rs1_data_i | rs2_data_i;
      FUNC_XOR: result_o = rs1_data_i ^ rs2_data_i;
      FUNC_NOT: result_o = ~rs1_data_i;
      default:  invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_gate.sv
// Bitwise logic unit of the execute stage: registers the combinational
// result, the valid flag and the unsupported-function flag.
module alu_gate
  import simple_processor_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  func_t                 func_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  valid_o,
  output logic                  invalid_o
);

  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_invalid;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_valid;
  logic                  r_invalid;

  alu_gate_comb u_comb (
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .func_i     (func_i),
    .result_o   (w_result),
    .invalid_o  (w_invalid)
  );

  // The result register only loads on a request, so the last write-back value
  // stays visible while the stage is idle.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!arst_ni) begin
      r_rd_data <= '0;
      r_valid   <= 1'b0;
      r_invalid <= 1'b0;
    end else begin
      r_valid   <= valid_i;
      r_invalid <= valid_i & w_invalid;
      if (valid_i) r_rd_data <= w_result;
    end
  end

  assign rd_data_o = r_rd_data;
  assign valid_o   = r_valid;
  assign invalid_o = r_invalid;

endmodule

// File: tb/tb_alu_gate.sv
// Self-checking bench for alu_gate: directed scenarios plus weighted random
// operations compared with a truth-table reference model.
module tb_alu_gate;
  import simple_processor_pkg::*;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic        valid_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  func_t       func_i;
  logic [31:0] rd_data_o;
  logic        valid_o;
  logic        invalid_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: what the outputs must show after the next edge.
  logic [31:0] exp_data;
  logic        exp_valid;
  logic        exp_invalid;

  alu_gate dut (
    .clk_i      (clk_i),
    .arst_ni    (arst_ni),
    .valid_i    (valid_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .func_i     (func_i),
    .rd_data_o  (rd_data_o),
    .valid_o    (valid_o),
    .invalid_o  (invalid_o)
  );

  always #5 clk_i = ~clk_i;

  // Each operation is a 2-input truth table indexed by {a_bit, b_bit}.
  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input int code);
    logic [3:0]  tt;
    logic [31:0] r;
    if (code > 3) return 32'd0;
    case (code)
      0:       tt = 4'b1000;
      1:       tt = 4'b1110;
      2:       tt = 4'b0110;
      default: tt = 4'b0011;
    endcase
    for (int i = 0; i < 32; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  // Drive one cycle of stimulus, advance the model, sample 1 ns after the edge.
  task automatic apply(input bit v, input logic [31:0] a, input logic [31:0] b, input int code);
    valid_i    = v;
    rs1_data_i = a;
    rs2_data_i = b;
    func_i     = func_t'(code[2:0]);
    if (v) begin
      exp_data    = ref_result(a, b, code);
      exp_valid   = 1'b1;
      exp_invalid = (code > 3);
    end else begin
      exp_valid   = 1'b0;
      exp_invalid = 1'b0;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    arst_ni = 1'b0;
    valid_i = 1'b1; rs1_data_i = $urandom; rs2_data_i = $urandom; func_i = FUNC_AND;
    #1;
    n_checks++;
    if ({rd_data_o, valid_o, invalid_o} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_initial: got data=%h v=%b inv=%b, want all zero", rd_data_o, valid_o, invalid_o);
    end
    for (int i = 0; i < 10; i++) begin
      rs1_data_i = $urandom; rs2_data_i = $urandom;
      func_i = func_t'(3'($urandom_range(0, 7)));
      @(posedge clk_i);
      #1;
      n_checks++;
      if ({rd_data_o, valid_o, invalid_o} !== 34'd0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got data=%h v=%b inv=%b, want all zero", i, rd_data_o, valid_o, invalid_o);
      end
    end
    arst_ni = 1'b1;
    exp_data = '0; exp_valid = 1'b0; exp_invalid = 1'b0;
  endtask

  task automatic test_and_or();
    apply(1'b1, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
    n_checks++;
    if ({rd_data_o, valid_o, invalid_o} !== {32'h00F0_1200, 2'b10}) begin
      n_fail++;
      $display("FAIL and_op: got data=%h v=%b inv=%b, want 00f01200 v=1 inv=0", rd_data_o, valid_o, invalid_o);
    end
    apply(1'b1, 32'hF0F0_1234, 32'h0FF0_FF00, 1);
    n_checks++;
    if ({rd_data_o, valid_o, invalid_o} !== {32'hFFF0_FF34, 2'b10}) begin
      n_fail++;
      $display("FAIL or_op: got data=%h v=%b inv=%b, want fff0ff34 v=1 inv=0", rd_data_o, valid_o, invalid_o);
    end
  endtask

  task automatic test_xor_not();
    apply(1'b1, 32'hAAAA_5555, 32'hFFFF_0000, 2);
    n_checks++;
    if ({rd_data_o, valid_o, invalid_o} !== {32'h5555_5555, 2'b10}) begin
      n_fail++;
      $display("FAIL xor_op: got data=%h v=%b inv=%b, want 55555555 v=1 inv=0", rd_data_o, valid_o, invalid_o);
    end
    apply(1'b1, 32'hAAAA_5555, 32'hFFFF_0000, 3);
    n_checks++;
    if ({rd_data_o, valid_o, invalid_o} !== {32'h5555_AAAA, 2'b10}) begin
      n_fail++;
      $display("FAIL not_op: got data=%h v=%b inv=%b, want 5555aaaa v=1 inv=0", rd_data_o, valid_o, invalid_o);
    end
    apply(1'b1, 32'hAAAA_5555, 32'h1234_9876, 3);
    n_checks++;
    if (rd_data_o !== 32'h5555_AAAA) begin
      n_fail++;
      $display("FAIL not_ignores_rs2: got data=%h, want 5555aaaa", rd_data_o);
    end
  endtask

  task automatic test_invalid();
    for (int code = 4; code < 8; code++) begin
      apply(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, code);
      n_checks++;
      if ({rd_data_o, valid_o, invalid_o} !== {32'd0, 2'b11}) begin
        n_fail++;
        $display("FAIL invalid_code_%0d: got data=%h v=%b inv=%b, want 0 v=1 inv=1", code, rd_data_o, valid_o, invalid_o);
      end
    end
    apply(1'b1, 32'hFFFF_FFFF, 32'h0000_FFFF, 0);
    n_checks++;
    if ({rd_data_o, valid_o, invalid_o} !== {32'h0000_FFFF, 2'b10}) begin
      n_fail++;
      $display("FAIL invalid_clears: got data=%h v=%b inv=%b, want 0000ffff v=1 inv=0", rd_data_o, valid_o, invalid_o);
    end
  endtask

  task automatic test_hold();
    apply(1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 0);
    n_checks++;
    if (rd_data_o !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL hold_load: got data=%h, want 12345678", rd_data_o);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, $urandom, $urandom, $urandom_range(0, 7));
      n_checks++;
      if ({rd_data_o, valid_o, invalid_o} !== {32'h1234_5678, 2'b00}) begin
        n_fail++;
        $display("FAIL hold[%0d]: got data=%h v=%b inv=%b, want 12345678 v=0 inv=0", i, rd_data_o, valid_o, invalid_o);
      end
    end
  endtask

  task automatic test_random();
    int r, code;
    for (int i = 0; i < 1000; i++) begin
      r = $urandom_range(0, 20);
      code = (r < 20) ? r / 5 : $urandom_range(4, 7);
      apply(1'b1, $urandom, $urandom, code);
      n_checks++;
      if ({rd_data_o, valid_o, invalid_o} !== {exp_data, exp_valid, exp_invalid}) begin
        n_fail++;
        $display("FAIL random[%0d] code=%0d: got data=%h v=%b inv=%b, want data=%h v=%b inv=%b",
                 i, code, rd_data_o, valid_o, invalid_o, exp_data, exp_valid, exp_invalid);
      end
      if (i == 500) begin
        #2;
        arst_ni = 1'b0;
        #1;
        n_checks++;
        if ({rd_data_o, valid_o, invalid_o} !== 34'd0) begin
          n_fail++;
          $display("FAIL async_reset_immediate: got data=%h v=%b inv=%b, want all zero", rd_data_o, valid_o, invalid_o);
        end
        @(posedge clk_i);
        #1;
        n_checks++;
        if ({rd_data_o, valid_o, invalid_o} !== 34'd0) begin
          n_fail++;
          $display("FAIL async_reset_hold: got data=%h v=%b inv=%b, want all zero", rd_data_o, valid_o, invalid_o);
        end
        arst_ni = 1'b1;
        exp_data = '0; exp_valid = 1'b0; exp_invalid = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_and_or();
    test_xor_not();
    test_invalid();
    test_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_gate.md
Name: alu_gate

Overview:
- Bitwise logic unit of the simple processor execute stage.
- Computes AND, OR, XOR or NOT on two source operands.
- Delivers the result as a registered write-back value for the destination register.
- Pure logic function with no arithmetic or carries; one-cycle registered latency.

Parameters:
- DATA_WIDTH, 32, width of operands and result (taken from the shared package).

Ports:
- clk_i  input  1  system clock, rising-edge active.
- arst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  operation request qualifier for the current cycle.
- rs1_data_i  input  DATA_WIDTH  source operand 1.
- rs2_data_i  input  DATA_WIDTH  source operand 2; ignored for NOT.
- func_i  input  3 (func_t)  operation select.
- rd_data_o  output  DATA_WIDTH  registered result.
- valid_o  output  1  rd_data_o holds a new result this cycle.
- invalid_o  output  1  the registered operation used an unsupported func_i code.

Behaviour:
- Interface: one clock, clk_i; reset arst_ni is asynchronous and active-low.
- Reset: on arst_ni low, immediately and independent of clk_i:
  - rd_data_o = 0, valid_o = 0, invalid_o = 0.
  - Outputs stay at these values while arst_ni is low.
- Function encoding (func_t):
  - AND = 3'd0 -> rs1 & rs2
  - OR = 3'd1 -> rs1 | rs2
  - XOR = 3'd2 -> rs1 ^ rs2
  - NOT = 3'd3 -> ~rs1
  - INVALID = 3'd4 and any other code 3'd4..3'd7 -> all-zero result, invalid_o = 1.
- Next-result logic is combinational on rs1_data_i, rs2_data_i and func_i, full DATA_WIDTH, bit-parallel, no sign handling.
- Rising clk_i edge with valid_i = 1:
  - rd_data_o <= computed result.
  - valid_o <= 1.
  - invalid_o <= 1 only for an unsupported code, else 0.
- Rising clk_i edge with valid_i = 0:
  - rd_data_o holds its previous value.
  - valid_o <= 0, invalid_o <= 0.
- Latency: inputs sampled at edge N appear on outputs after edge N.
  - Back-to-back valid_i gives one result per cycle; no stall or backpressure.
- Reset de-asserted mid-stream: the first edge after release behaves as a normal edge; no result from before reset is retained.
- Inputs are X-free by contract; no internal state other than the three output registers.

Decomposition:
- simple_processor_pkg holds:
  - DATA_WIDTH (32).
  - func_t enum (AND, OR, XOR, NOT, INVALID), 3-bit logic-based.
- Optional sub-module alu_gate_comb: purely combinational result + invalid-flag decode.
  - alu_gate instantiates it and adds the output register stage.

Test Plan:
1. Reset: hold arst_ni = 0 for 100 ns with random inputs -> rd_data_o = 0, valid_o = 0, invalid_o = 0 throughout; no change on clk_i edges.
2. AND/OR: rs1 = 32'hF0F0_1234, rs2 = 32'h0FF0_FF00, valid_i = 1.
   - func AND -> next cycle rd_data_o = 32'h00F0_1200, valid_o = 1.
   - func OR -> 32'hFFF0_FF34.
3. XOR/NOT: rs1 = 32'hAAAA_5555, rs2 = 32'hFFFF_0000.
   - XOR -> 32'h5555_5555.
   - NOT -> 32'h5555_AAAA; rs2 has no effect.
4. Invalid code: func_i = 3'd4 (also 3'd7), rs1 = rs2 = 32'hFFFF_FFFF -> rd_data_o = 0, invalid_o = 1, valid_o = 1.
5. Hold: valid AND result 32'h1234_5678, then valid_i = 0 for 3 cycles with changing operands -> rd_data_o stays 32'h1234_5678, valid_o = 0.
6. Random: 1000 cycles of random operands and func_i, weighted 5:5:5:5:1 for AND:OR:XOR:NOT:INVALID, valid_i = 1.
   - Each output matches a one-cycle-delayed reference model.
   - Assert arst_ni low asynchronously mid-run -> outputs clear immediately.
